// File: rtl/hazard_stall_ctrl_if.sv
// Handshake bundle between the pipeline and the stall/flush controller.
//
// Pipeline -> controller (driven by the master):
//   D_Rs, D_Rt          source register fields of the instruction in D
//   D_TuseRs, D_TuseRt  cycles until D needs rs / rt (3 = never)
//   D_IsMD              D instruction is mult/div/mfhi/mflo/mthi/mtlo
//   E_WA, E_Tnew        E-stage destination (0 = none) and its Tnew
//   M_WA, M_Tnew        M-stage destination (0 = none) and its Tnew
//   E_MDStart, E_IsDiv  multiply/divide start in E (E_IsDiv: 1 = div)
// Controller -> pipeline (driven by the slave):
//   Stop_PC, Stop_DR    hold the PC and the D-stage register
//   Flush_ER            load a bubble into the E register
//   MD_Busy             multiply/divide unit busy (registered)
//   Stall_Cnt, MD_Stall_Cnt  performance counters, present only when
//                            STALL_CTRL_PERF_EN is defined
interface hazard_stall_ctrl_if;
  logic [4:0]  D_Rs;
  logic [4:0]  D_Rt;
  logic [1:0]  D_TuseRs;
  logic [1:0]  D_TuseRt;
  logic        D_IsMD;
  logic [4:0]  E_WA;
  logic [1:0]  E_Tnew;
  logic [4:0]  M_WA;
  logic [1:0]  M_Tnew;
  logic        E_MDStart;
  logic        E_IsDiv;
  logic        Stop_PC;
  logic        Stop_DR;
  logic        Flush_ER;
  logic        MD_Busy;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0] Stall_Cnt;
  logic [31:0] MD_Stall_Cnt;
`endif

  modport master (
    output D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_IsMD,
    output E_WA, E_Tnew, M_WA, M_Tnew, E_MDStart, E_IsDiv,
`ifdef STALL_CTRL_PERF_EN
    input  Stall_Cnt, MD_Stall_Cnt,
`endif
    input  Stop_PC, Stop_DR, Flush_ER, MD_Busy
  );

  modport slave (
    input  D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_IsMD,
    input  E_WA, E_Tnew, M_WA, M_Tnew, E_MDStart, E_IsDiv,
`ifdef STALL_CTRL_PERF_EN
    output Stall_Cnt, MD_Stall_Cnt,
`endif
    output Stop_PC, Stop_DR, Flush_ER, MD_Busy
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
//
// Each cycle decides whether to freeze the PC and D-stage register and
// bubble the E register. Stalls come from RAW hazards forwarding cannot
// cover (Tuse < Tnew) and from a D-stage HI/LO/mult/div instruction while
// the multiply/divide unit is starting or busy. Also owns the MDU busy FSM.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    hazard_stall_ctrl_if.slave (see interface header for members)
//
// Parameters:
//   MULT_CYCLES  busy cycles after a mult/multu start (>=1)
//   DIV_CYCLES   busy cycles after a div/divu start (>=1)
//   CNT_W        busy counter width, must hold max(MULT_CYCLES, DIV_CYCLES)
//
// Optional feature: define STALL_CTRL_PERF_EN to add the Stall_Cnt and
// MD_Stall_Cnt cycle counters. Without it no counter logic exists.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             md_busy;
  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;
  logic             stall;
  logic [CNT_W-1:0] load_val;

  assign md_busy  = (state == BUSY);
  assign load_val = bus.E_IsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Register 0 never stalls; Tnew==0 never stalls because Tuse < 0 is false.
  assign stall_rs = (bus.D_Rs != 5'd0) &&
                    (((bus.D_Rs == bus.E_WA) && (bus.D_TuseRs < bus.E_Tnew)) ||
                     ((bus.D_Rs == bus.M_WA) && (bus.D_TuseRs < bus.M_Tnew)));
  assign stall_rt = (bus.D_Rt != 5'd0) &&
                    (((bus.D_Rt == bus.E_WA) && (bus.D_TuseRt < bus.E_Tnew)) ||
                     ((bus.D_Rt == bus.M_WA) && (bus.D_TuseRt < bus.M_Tnew)));
  // The start pulse itself blocks MD instructions, before MD_Busy rises.
  assign stall_md = bus.D_IsMD && (bus.E_MDStart || md_busy);
  assign stall    = stall_rs | stall_rt | stall_md;

  assign bus.Stop_PC  = stall & ~reset;
  assign bus.Stop_DR  = stall & ~reset;
  assign bus.Flush_ER = stall & ~reset;
  assign bus.MD_Busy  = md_busy;

  // MDU busy FSM: busy for exactly N cycles after the start cycle.
  // A start while BUSY reloads the count, so the newest start wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.E_MDStart) begin
      state <= BUSY;
      cnt   <= load_val;
    end else if (state == BUSY) begin
      if (cnt > CNT_W'(1)) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        cnt   <= '0;
        state <= IDLE;
      end
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall)    stall_cnt    <= stall_cnt + 32'd1;
      if (stall_md) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end

  assign bus.Stall_Cnt    = stall_cnt;
  assign bus.MD_Stall_Cnt = md_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: MDU busy is described as the window of cycles
  // (start, start+N] of the most recent start, cancelled by reset.
  int cyc      = 0;
  int ms_start = 0;
  int ms_n     = 0;
  bit ms_valid = 0;
`ifdef STALL_CTRL_PERF_EN
  longint m_stall_cnt = 0;
  longint m_md_cnt    = 0;
`endif

  function automatic bit model_busy();
    return ms_valid && (cyc > ms_start) && (cyc <= ms_start + ms_n);
  endfunction

  function automatic bit model_md_stall();
    return bus.D_IsMD && (bus.E_MDStart || model_busy());
  endfunction

  function automatic bit model_stall();
    bit srs, srt;
    srs = (bus.D_Rs != 0) &&
          ((bus.D_Rs == bus.E_WA && int'(bus.D_TuseRs) < int'(bus.E_Tnew)) ||
           (bus.D_Rs == bus.M_WA && int'(bus.D_TuseRs) < int'(bus.M_Tnew)));
    srt = (bus.D_Rt != 0) &&
          ((bus.D_Rt == bus.E_WA && int'(bus.D_TuseRt) < int'(bus.E_Tnew)) ||
           (bus.D_Rt == bus.M_WA && int'(bus.D_TuseRt) < int'(bus.M_Tnew)));
    if (reset) return 1'b0;
    return srs || srt || model_md_stall();
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic clk_edge();
    @(posedge clk);
`ifdef STALL_CTRL_PERF_EN
    if (reset) begin
      m_stall_cnt = 0;
      m_md_cnt    = 0;
    end else begin
      if (model_stall())    m_stall_cnt = (m_stall_cnt + 1) % 64'h1_0000_0000;
      if (model_md_stall()) m_md_cnt    = (m_md_cnt + 1) % 64'h1_0000_0000;
    end
`endif
    if (reset) ms_valid = 0;
    else if (bus.E_MDStart) begin
      ms_valid = 1;
      ms_start = cyc;
      ms_n     = bus.E_IsDiv ? DIV_N : MULT_N;
    end
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    bus.D_Rs = 0; bus.D_Rt = 0; bus.D_TuseRs = 3; bus.D_TuseRt = 3;
    bus.D_IsMD = 0; bus.E_WA = 0; bus.E_Tnew = 0; bus.M_WA = 0;
    bus.M_Tnew = 0; bus.E_MDStart = 0; bus.E_IsDiv = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    set_idle();
    bus.E_WA = 5; bus.E_Tnew = 2; bus.D_Rs = 5; bus.D_TuseRs = 1;
    clk_edge();
    clk_edge();
    @(negedge clk);
    n_checks++;
    if ({bus.Stop_PC, bus.Stop_DR, bus.Flush_ER} !== 3'b000)
      $display("FAIL reset_outputs: got %b want 000", {bus.Stop_PC, bus.Stop_DR, bus.Flush_ER});
    else n_pass++;
    n_checks++;
    if (bus.MD_Busy !== 1'b0) $display("FAIL reset_md_busy: got %b want 0", bus.MD_Busy);
    else n_pass++;
    clk_edge();
    reset = 0;
    set_idle();
    clk_edge();
  endtask

  task automatic test_load_use();
    set_idle();
    bus.E_WA = 5; bus.E_Tnew = 2; bus.D_Rs = 5; bus.D_TuseRs = 1;
    @(negedge clk);
    n_checks++;
    if ({bus.Stop_PC, bus.Stop_DR, bus.Flush_ER} !== 3'b111)
      $display("FAIL load_use_stall: got %b want 111", {bus.Stop_PC, bus.Stop_DR, bus.Flush_ER});
    else n_pass++;
    bus.E_Tnew = 1;
    #1;
    n_checks++;
    if ({bus.Stop_PC, bus.Stop_DR, bus.Flush_ER} !== 3'b000)
      $display("FAIL load_use_tnew1: got %b want 000", {bus.Stop_PC, bus.Stop_DR, bus.Flush_ER});
    else n_pass++;
    bus.E_Tnew = 0; bus.D_TuseRs = 0;
    #1;
    n_checks++;
    if (bus.Stop_PC !== 1'b0) $display("FAIL tnew0_no_stall: got %b want 0", bus.Stop_PC);
    else n_pass++;
    clk_edge();
  endtask

  task automatic test_zero_reg();
    set_idle();
    bus.E_WA = 0; bus.D_Rs = 0; bus.E_Tnew = 2; bus.D_TuseRs = 0;
    bus.M_WA = 0; bus.M_Tnew = 2; bus.D_Rt = 0; bus.D_TuseRt = 0;
    @(negedge clk);
    n_checks++;
    if (bus.Stop_PC !== 1'b0) $display("FAIL zero_reg: got %b want 0", bus.Stop_PC);
    else n_pass++;
    clk_edge();
  endtask

  task automatic test_m_stage();
    set_idle();
    bus.M_WA = 7; bus.M_Tnew = 1; bus.D_Rt = 7; bus.D_TuseRt = 0;
    @(negedge clk);
    n_checks++;
    if (bus.Flush_ER !== 1'b1) $display("FAIL m_stage_stall: got %b want 1", bus.Flush_ER);
    else n_pass++;
    bus.D_TuseRt = 1;
    #1;
    n_checks++;
    if (bus.Flush_ER !== 1'b0) $display("FAIL m_stage_tuse1: got %b want 0", bus.Flush_ER);
    else n_pass++;
    clk_edge();
  endtask

  task automatic test_mult();
    set_idle();
    bus.D_IsMD = 1; bus.E_MDStart = 1; bus.E_IsDiv = 0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.Stop_PC !== ((k <= 5) ? 1'b1 : 1'b0))
        $display("FAIL mult_stall t+%0d: got %b want %b", k, bus.Stop_PC, (k <= 5));
      else n_pass++;
      n_checks++;
      if (bus.MD_Busy !== ((k >= 1 && k <= 5) ? 1'b1 : 1'b0))
        $display("FAIL mult_busy t+%0d: got %b want %b", k, bus.MD_Busy, (k >= 1 && k <= 5));
      else n_pass++;
      clk_edge();
      bus.E_MDStart = 0;
    end
  endtask

  task automatic test_non_md();
    set_idle();
    bus.E_MDStart = 1; bus.E_IsDiv = 0;
    clk_edge();
    bus.E_MDStart = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.MD_Busy, bus.Stop_PC} !== 2'b10)
        $display("FAIL non_md t+%0d: busy,stall got %b want 10", k, {bus.MD_Busy, bus.Stop_PC});
      else n_pass++;
      clk_edge();
    end
    for (int k = 0; k < 4; k++) clk_edge();
  endtask

  task automatic test_div_reset();
    set_idle();
    bus.D_IsMD = 1; bus.E_MDStart = 1; bus.E_IsDiv = 1;
    for (int k = 0; k <= 5; k++) begin
      if (k == 3) reset = 1;
      if (k == 5) reset = 0;
      @(negedge clk);
      n_checks++;
      if (bus.MD_Busy !== ((k >= 1 && k <= 3) ? 1'b1 : 1'b0))
        $display("FAIL div_reset_busy t+%0d: got %b want %b", k, bus.MD_Busy, (k >= 1 && k <= 3));
      else n_pass++;
      n_checks++;
      if (bus.Stop_DR !== ((k <= 2) ? 1'b1 : 1'b0))
        $display("FAIL div_reset_stall t+%0d: got %b want %b", k, bus.Stop_DR, (k <= 2));
      else n_pass++;
      clk_edge();
      bus.E_MDStart = 0;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      bus.D_Rs = 5'($urandom_range(0, 3));
      bus.D_Rt = 5'($urandom_range(0, 3));
      bus.D_TuseRs = 2'($urandom);
      bus.D_TuseRt = 2'($urandom);
      bus.D_IsMD = ($urandom_range(0, 2) == 0);
      bus.E_WA = 5'($urandom_range(0, 3));
      bus.E_Tnew = 2'($urandom);
      bus.M_WA = 5'($urandom_range(0, 3));
      bus.M_Tnew = 2'($urandom);
      bus.E_MDStart = ($urandom_range(0, 11) == 0);
      bus.E_IsDiv = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if ({bus.Stop_PC, bus.Stop_DR, bus.Flush_ER} !== {3{model_stall()}})
        $display("FAIL rand_stall cyc %0d: got %b want %b", cyc,
                 {bus.Stop_PC, bus.Stop_DR, bus.Flush_ER}, {3{model_stall()}});
      else n_pass++;
      n_checks++;
      if (bus.MD_Busy !== model_busy())
        $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, bus.MD_Busy, model_busy());
      else n_pass++;
`ifdef STALL_CTRL_PERF_EN
      n_checks++;
      if (bus.Stall_Cnt !== m_stall_cnt[31:0] || bus.MD_Stall_Cnt !== m_md_cnt[31:0])
        $display("FAIL rand_perf cyc %0d: got %0d/%0d want %0d/%0d", cyc,
                 bus.Stall_Cnt, bus.MD_Stall_Cnt, m_stall_cnt, m_md_cnt);
      else n_pass++;
`endif
      clk_edge();
    end
    reset = 0;
    set_idle();
  endtask

`ifdef STALL_CTRL_PERF_EN
  task automatic test_perf();
    set_idle();
    reset = 1;
    clk_edge();
    reset = 0;
    bus.E_WA = 5; bus.E_Tnew = 2; bus.D_Rs = 5; bus.D_TuseRs = 1;
    for (int k = 0; k < 3; k++) clk_edge();
    set_idle();
    bus.D_IsMD = 1; bus.E_MDStart = 1;
    clk_edge();
    bus.E_MDStart = 0;
    for (int k = 0; k < 7; k++) clk_edge();
    @(negedge clk);
    n_checks++;
    if (bus.Stall_Cnt !== 32'd9 || bus.MD_Stall_Cnt !== 32'd6)
      $display("FAIL perf_counts: got %0d/%0d want 9/6", bus.Stall_Cnt, bus.MD_Stall_Cnt);
    else n_pass++;
    set_idle();
    clk_edge();
  endtask
`endif

  initial begin
    reset = 1;
    set_idle();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_m_stage();
    test_mult();
    test_non_md();
    test_div_reset();
`ifdef STALL_CTRL_PERF_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
